// File: rtl/fp_add_accumulator_if.sv
// Stream/adder/result bundle for fp_add_accumulator.
// slave  : the accumulator's view (consumes elements, drives the adder operands and the result)
// master : the environment's view (element source, adder, result consumer)
interface fp_add_accumulator_if #(
  parameter int CNT_W = 16
);
  // Element input stream
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  // Combinational FP adder
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic [31:0]      add_sum;
  logic             add_uo;
  // Result output
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_flag;

  modport slave (
    input  in_valid, in_data, in_last, add_sum, add_uo, out_ready,
    output in_ready, add_a, add_b, out_valid, out_data, out_count, out_flag
  );

  modport master (
    output in_valid, in_data, in_last, add_sum, add_uo, out_ready,
    input  in_ready, add_a, add_b, out_valid, out_data, out_count, out_flag
  );
endinterface

// File: rtl/fp_add_accumulator.sv
// Float32 stream accumulator wrapped around an external combinational FP adder.
// The first element loads the running sum directly; every later element is
// presented to the adder for ADD_LATENCY cycles and the result is captured.
// Optional build macro FP_ACC_ZERO_BYPASS_EN: zero operands bypass the adder,
// because its implicit leading 1 mis-handles them.
module fp_add_accumulator #(
  parameter int ADD_LATENCY = 2,   // 1..15
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp_add_accumulator_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(ADD_LATENCY - 1);

  state_t           state_q, state_d;
  logic [31:0]      acc;
  logic [31:0]      opnd;
  logic [CNT_W-1:0] count;
  logic             flag;
  logic [3:0]       wait_cnt;
  logic             last_q;

  logic             in_fire;
  logic             elem_zero;
  logic             bypass;
  logic [CNT_W-1:0] count_inc;

  assign in_fire   = bus.in_valid && bus.in_ready;
  assign count_inc = (&count) ? count : count + 1'b1;

`ifdef FP_ACC_ZERO_BYPASS_EN
  assign elem_zero = (bus.in_data[30:0] == 31'd0);
  assign bypass    = elem_zero || (acc[30:0] == 31'd0);
`else
  assign elem_zero = 1'b0;
  assign bypass    = 1'b0;
`endif

  assign bus.add_a     = acc;
  assign bus.add_b     = opnd;
  assign bus.out_data  = acc;
  assign bus.out_count = count;
  assign bus.out_flag  = flag;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake decode; in_ready/out_valid depend on state only.
  // NOTE: every output of this block is defaulted first so no latch can be inferred.
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (in_fire) state_d = bus.in_last ? S_DONE : S_ACCUM;
      end
      S_ACCUM: begin
        bus.in_ready = 1'b1;
        if (in_fire) begin
          if (bypass) state_d = bus.in_last ? S_DONE : S_ACCUM;
          else        state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt == 4'd0) state_d = last_q ? S_DONE : S_ACCUM;
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: running sum, latched operand, element count, sticky flag, wait timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= 32'd0;
      opnd     <= 32'd0;
      count    <= '0;
      flag     <= 1'b0;
      wait_cnt <= 4'd0;
      last_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_fire) begin
            acc   <= bus.in_data;
            count <= {{(CNT_W-1){1'b0}}, 1'b1};
            flag  <= 1'b0;
          end
        end
        S_ACCUM: begin
          if (in_fire) begin
            if (bypass) begin
              // Zero element leaves the sum alone; zero sum takes the element.
              if (!elem_zero) acc <= bus.in_data;
              count <= count_inc;
            end else begin
              opnd     <= bus.in_data;
              last_q   <= bus.in_last;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            acc   <= bus.add_sum;
            flag  <= flag | bus.add_uo;
            count <= count_inc;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_accumulator.sv
// Self-checking bench for fp_add_accumulator: directed streams, a small
// positive-operand FP adder model, and a scoreboard checked by a monitor.
module tb_fp_add_accumulator;

  localparam int ADD_LAT = 2;
  localparam int CNT_W   = 3;   // small so count saturation is reachable

  typedef struct packed {
    logic [31:0]      data;
    logic [CNT_W-1:0] count;
    logic             flag;
  } result_t;

  logic clk;
  logic rst_n;
  int   tests    = 0;
  int   failures = 0;
  result_t sb_q[$];

  fp_add_accumulator_if #(.CNT_W(CNT_W)) bus ();

  fp_add_accumulator #(
    .ADD_LATENCY (ADD_LAT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Positive-operand float32 adder with truncation; overflow gives +inf and uo=1.
  function automatic logic [32:0] fp_add_model(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  ea, eb, et;
    logic [23:0] ma, mb, mt;
    logic [24:0] s;
    int          e, d;
    if (a[30:0] == 31'd0) return {1'b0, b};
    if (b[30:0] == 31'd0) return {1'b0, a};
    ea = a[30:23]; eb = b[30:23];
    ma = {1'b1, a[22:0]}; mb = {1'b1, b[22:0]};
    if (ea < eb) begin
      et = ea; ea = eb; eb = et;
      mt = ma; ma = mb; mb = mt;
    end
    d  = int'(ea) - int'(eb);
    mb = (d > 24) ? 24'd0 : (mb >> d);
    s  = {1'b0, ma} + {1'b0, mb};
    e  = int'(ea);
    if (s[24]) begin
      s = s >> 1;
      e = e + 1;
    end
    if (e >= 255) return {1'b1, 32'h7F80_0000};
    return {1'b0, 1'b0, e[7:0], s[22:0]};
  endfunction

  always_comb {bus.add_uo, bus.add_sum} = fp_add_model(bus.add_a, bus.add_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: pops one expected result per output transfer.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        tests++;
        failures++;
        $display("FAIL sb_unexpected: output 0x%08h with empty scoreboard", bus.out_data);
      end else begin
        result_t r;
        r = sb_q.pop_front();
        check("sb_data",  bus.out_data,                r.data);
        check("sb_count", 32'(bus.out_count),          32'(r.count));
        check("sb_flag",  {31'd0, bus.out_flag},       {31'd0, r.flag});
      end
    end
  end

  function automatic result_t mk(input logic [31:0] d, input int c, input logic f);
    result_t r;
    r.data  = d;
    r.count = CNT_W'(c);
    r.flag  = f;
    return r;
  endfunction

  // Offer one element; when it went through the adder, check the WAIT window.
  task automatic send(input logic [31:0] d, input logic last, input bit adder_path);
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!done) begin
      tests++;
      failures++;
      $display("FAIL send_timeout: in_ready never high for 0x%08h", d);
    end else if (adder_path) begin
      for (int i = 0; i < ADD_LAT; i++) begin
        @(negedge clk);
        check("wait_in_ready",  {31'd0, bus.in_ready},  32'd0);
        check("wait_out_valid", {31'd0, bus.out_valid}, 32'd0);
      end
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_add_a",     bus.add_a,              32'd0);
    check("rst_add_b",     bus.add_b,              32'd0);
    check("rst_count",     32'(bus.out_count),     32'd0);
    check("rst_flag",      {31'd0, bus.out_flag},  32'd0);
    rst_n = 1'b1;

    // Single element: straight to DONE, adder operand untouched.
    sb_q.push_back(mk(32'h3F80_0000, 1, 1'b0));
    send(32'h3F80_0000, 1'b1, 1'b0);
    @(negedge clk);
    check("t1_done",  {31'd0, bus.out_valid}, 32'd1);
    check("t1_add_b", bus.add_b,              32'd0);

    // 1.0 + 2.0: DONE exactly ADD_LAT+1 cycles after the accept cycle.
    send(32'h3F80_0000, 1'b0, 1'b0);
    sb_q.push_back(mk(32'h4040_0000, 2, 1'b0));
    send(32'h4000_0000, 1'b1, 1'b1);
    @(negedge clk);
    check("t2_latency", {31'd0, bus.out_valid}, 32'd1);

    // Gapped 1 + 2 + 3 = 6.
    send(32'h3F80_0000, 1'b0, 1'b0);
    gap(3);
    send(32'h4000_0000, 1'b0, 1'b1);
    gap(2);
    sb_q.push_back(mk(32'h40C0_0000, 3, 1'b0));
    send(32'h4040_0000, 1'b1, 1'b1);
    @(negedge clk);
    check("t3_done", {31'd0, bus.out_valid}, 32'd1);

    // Overflow: 2^127 + 2^127 -> +inf, sticky flag.
    send(32'h7F00_0000, 1'b0, 1'b0);
    sb_q.push_back(mk(32'h7F80_0000, 2, 1'b1));
    send(32'h7F00_0000, 1'b1, 1'b1);
    @(negedge clk);
    check("t4_done", {31'd0, bus.out_valid}, 32'd1);

    // Count saturation: nine 1.0 elements, count holds at 7, sum 9.0.
    send(32'h3F80_0000, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) send(32'h3F80_0000, 1'b0, 1'b1);
    sb_q.push_back(mk(32'h4110_0000, 7, 1'b0));
    send(32'h3F80_0000, 1'b1, 1'b1);
    @(negedge clk);
    check("t5_done", {31'd0, bus.out_valid}, 32'd1);

    // Output back-pressure: result held stable, no input accepted.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(32'h3F80_0000, 1'b0, 1'b0);
    sb_q.push_back(mk(32'h4040_0000, 2, 1'b0));
    send(32'h4000_0000, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid",    {31'd0, bus.out_valid}, 32'd1);
      check("stall_data",     bus.out_data,           32'h4040_0000);
      check("stall_count",    32'(bus.out_count),     32'd2);
      check("stall_in_ready", {31'd0, bus.in_ready},  32'd0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("post_out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Reset asserted mid-WAIT, then a fresh single-element stream.
    send(32'h3F80_0000, 1'b0, 1'b0);
    send(32'h4000_0000, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mrst_add_a",     bus.add_a,              32'd0);
    check("mrst_add_b",     bus.add_b,              32'd0);
    check("mrst_data",      bus.out_data,           32'd0);
    check("mrst_count",     32'(bus.out_count),     32'd0);
    check("mrst_flag",      {31'd0, bus.out_flag},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back(mk(32'h3FC0_0000, 1, 1'b0));
    send(32'h3FC0_0000, 1'b1, 1'b0);
    @(negedge clk);
    check("t6_done", {31'd0, bus.out_valid}, 32'd1);

    @(posedge clk);
    @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/fp_add_accumulator.md
Name: fp_add_accumulator

Overview:
- Sequential controller that sums a stream of IEEE-754 single-precision values using the existing combinational FP adder.
- Sits directly around the adder: drives its two operand inputs and consumes its result and under/overflow flag.
- Holds the running sum in a register and returns the final sum, element count and sticky overflow flag over a valid/ready output.

Parameters:
ADD_LATENCY, 2, cycles operands are held stable on the adder before the result is captured (legal range 1..15)
CNT_W, 16, width of the element counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input element valid
in_ready  output  1  block can accept an element
in_data  input  32  float32 element
in_last  input  1  marks final element of the stream
add_a  output  32  adder operand 1 (running sum)
add_b  output  32  adder operand 2 (latched element)
add_sum  input  32  adder result
add_uo  input  1  adder under/overflow flag
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  32  final sum
out_count  output  CNT_W  number of elements summed
out_flag  output  1  sticky OR of add_uo over the stream

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset (async, any state, including mid-WAIT): state=IDLE, acc=0, opnd=0, count=0, flag=0, wait counter=0, last_q=0, out_valid=0.
- Outputs: add_a=acc and add_b=opnd at all times; out_data=acc; out_count=count; out_flag=flag.
- Handshakes: an input transfer occurs when in_valid&&in_ready; an output transfer when out_valid&&out_ready.
- IDLE: in_ready=1.
  - On transfer: acc<=in_data, count<=1, flag<=0.
  - Next state is DONE if in_last, else ACCUM.
  - The first element never passes through the adder.
- ACCUM: in_ready=1.
  - On transfer: opnd<=in_data, last_q<=in_last, wait counter<=ADD_LATENCY-1, next state WAIT.
  - No transfer: remain in ACCUM.
- WAIT: in_ready=0. Decrement the counter each cycle.
  - In the cycle the counter is 0: acc<=add_sum, flag<=flag|add_uo, and count<=count+1 (saturating at all-ones).
  - Next state is DONE if last_q, else ACCUM.
  - Total ADD_LATENCY cycles spent in WAIT.
- DONE: in_ready=0, out_valid=1.
  - out_data, out_count and out_flag stay stable until the output transfer.
  - On transfer: next state IDLE; count and flag clear on the next accept in IDLE.
- Per-element latency: 1 accept cycle + ADD_LATENCY cycles. Element throughput is 1 per (ADD_LATENCY+1) cycles.
- in_ready is a registered-state decode with no combinational path from out_ready. An input and an output transfer can never occur in the same cycle.
- Overflow handling: an overflowing sum is still captured as-is; accumulation continues and flag stays 1.
- Counter wrap: count does not wrap; it holds at 2^CNT_W-1.

Optional Feature:
FP_ACC_ZERO_BYPASS_EN
- Defined: the adder's implicit leading 1 mis-handles zero operands, so zeros bypass it. In ACCUM, an accepted element with bits[30:0]==0 skips WAIT: acc unchanged, count+1, next state DONE if in_last, else ACCUM. In the same state, if acc[30:0]==0 and the element is nonzero: acc<=in_data, count+1, WAIT skipped.
- Undefined: every element after the first goes through the adder and WAIT.

Test Plan:
- Single element 0x3F800000 with in_last -> DONE next cycle; out_data=0x3F800000, out_count=1, out_flag=0; add path unused.
- Stream 0x3F800000, 0x40000000(last), adder model connected -> out_data=0x40400000, out_count=2, out_valid exactly ADD_LATENCY+1 cycles after the second accept.
- Stream 0x3F800000, 0x40000000, 0x40400000(last) with in_valid gapped -> out_data=0x40C00000, out_count=3; in_ready low throughout every WAIT.
- Stream 0x7F000000, 0x7F000000(last) -> add_uo=1 captured, out_flag=1, out_data=0x7F800000.
- out_ready held low 5 cycles in DONE -> out_valid, out_data and out_count stable and in_ready=0; after out_ready=1, state returns to IDLE and in_ready=1 next cycle.
- rst_n asserted mid-WAIT -> all outputs clear immediately, out_valid=0; after release, a new single-element stream 0x3FC00000 returns 0x3FC00000 with count=1.
